// File: rtl/gtp_wr_pkg.sv
// Shared definitions for the MCB port 2 GTP write scheduler:
// FSM encoding, MCB command opcode and status word layout.
package gtp_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_XFER = 3'd1,
    ST_CMD  = 3'd2
  } state_t;

  localparam logic [2:0] MCB_CMD_WR_AP = 3'b010;

  localparam int STAT_STATE_LSB  = 0;
  localparam int STAT_RING_FULL  = 3;
  localparam int STAT_LAST_LSB   = 4;
  localparam int STAT_BLKCNT_LSB = 16;

endpackage

// File: rtl/gtp_wr_sched_if.sv
// MCB port 2 write-data and command bus, seen from the scheduler (master)
// and from the memory controller (slave).
interface gtp_wr_sched_if;

  logic        p2_wr_en;
  logic [31:0] p2_wr_data;
  logic [3:0]  p2_wr_mask;
  logic        p2_wr_full;
  logic        p2_cmd_en;
  logic [2:0]  p2_cmd_instr;
  logic [5:0]  p2_cmd_bl;
  logic [29:0] p2_cmd_byte_addr;
  logic        p2_cmd_full;

  modport master (
    output p2_wr_en, p2_wr_data, p2_wr_mask,
    output p2_cmd_en, p2_cmd_instr, p2_cmd_bl, p2_cmd_byte_addr,
    input  p2_wr_full, p2_cmd_full
  );

  modport slave (
    input  p2_wr_en, p2_wr_data, p2_wr_mask,
    input  p2_cmd_en, p2_cmd_instr, p2_cmd_bl, p2_cmd_byte_addr,
    output p2_wr_full, p2_cmd_full
  );

endinterface

// File: rtl/gtp_wr_sched_rr_arb4.sv
// Four-way round-robin arbiter: grants the first requester after 'last'.
// Purely combinational; the caller registers the grant.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       gnt_vld,
  output logic [1:0] gnt
);

  logic [1:0] idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = last;
    idx     = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

endmodule

// File: rtl/gtp_wr_sched.sv
// Drains four channel FIFOs into MCB port 2 in fixed blocks over a circular SDRAM region.
// Optional partial-block flush on idle timeout when GTP_WR_FLUSH_EN is defined.
module gtp_wr_sched #(
  parameter int          BLOCK_LEN  = 16,
  parameter logic [28:0] RING_BASE  = 29'h0000000,
  parameter logic [28:0] RING_BYTES = 29'h1000000
`ifdef GTP_WR_FLUSH_EN
  ,
  parameter int          FLUSH_CYCLES = 1024
`endif
) (
  input  logic           wb_clk,
  input  logic           wb_rst,
  input  logic           enable,
  input  logic [127:0]   ch_dat,
  input  logic [3:0]     ch_empty,
  input  logic [3:0]     ch_rdy,
  output logic [3:0]     ch_rd,
  input  logic [28:0]    rd_ptr,
  output logic [28:0]    wr_ptr,
  output logic [31:0]    status,
  gtp_wr_sched_if.master p2
);

  import gtp_wr_pkg::*;

  localparam logic [6:0]  BLK_WORDS = 7'(BLOCK_LEN);
  localparam logic [29:0] BLK_BYTES = 30'(4 * BLOCK_LEN);
  localparam logic [29:0] RING_END  = {1'b0, RING_BASE} + {1'b0, RING_BYTES};

  state_t      state, state_nxt;
  logic [1:0]  sel, last;
  logic [6:0]  wcnt, wcnt_m1;
  logic [15:0] blk_cnt;
  logic [3:0]  req;
  logic        gnt_vld;
  logic [1:0]  gnt;
  logic        grant, pop, cmd_fire, ring_full;
  logic [29:0] ring_dist, ptr_adv;

  rr_arb4 u_arb (.req(req), .last(last), .gnt_vld(gnt_vld), .gnt(gnt));

`ifdef GTP_WR_FLUSH_EN
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt [4];
  logic [3:0]        flush_rdy;

  // A channel stuck below a full block ages until it may be flushed.
  always_ff @(posedge wb_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wb_rst || ch_empty[i] || (grant && gnt == 2'(i)))
        idle_cnt[i] <= '0;
      else if (!ch_rdy[i] && idle_cnt[i] != IDLE_W'(FLUSH_CYCLES))
        idle_cnt[i] <= idle_cnt[i] + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) flush_rdy[i] = (idle_cnt[i] == IDLE_W'(FLUSH_CYCLES));
  end

  assign req = ch_rdy | flush_rdy;
`else
  assign req = ch_rdy;
`endif

  // Distance the producer may still advance before touching the consumer's block.
  always_comb begin
    if (rd_ptr >= wr_ptr) ring_dist = {1'b0, rd_ptr} - {1'b0, wr_ptr};
    else                  ring_dist = {1'b0, rd_ptr} + {1'b0, RING_BYTES} - {1'b0, wr_ptr};
  end

  assign ring_full = (ring_dist != '0) && (ring_dist <= BLK_BYTES);
  assign ptr_adv   = {1'b0, wr_ptr} + BLK_BYTES;
  assign wcnt_m1   = wcnt - 7'd1;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pop       = 1'b0;
    cmd_fire  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !ring_full && gnt_vld) begin
          grant     = 1'b1;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        pop = (wcnt < BLK_WORDS) && !ch_empty[sel] && !p2.p2_wr_full;
        if (pop && (wcnt + 7'd1 == BLK_WORDS))
          state_nxt = ST_CMD;
`ifdef GTP_WR_FLUSH_EN
        else if (ch_empty[sel] && wcnt != 7'd0)
          state_nxt = ST_CMD;
`endif
      end
      ST_CMD: begin
        if (!p2.p2_cmd_full) begin
          cmd_fire  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (wb_rst) begin
      grant    = 1'b0;
      pop      = 1'b0;
      cmd_fire = 1'b0;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state   <= ST_IDLE;
      sel     <= 2'd0;
      last    <= 2'd3;
      wcnt    <= 7'd0;
      wr_ptr  <= RING_BASE;
      blk_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        sel  <= gnt;
        wcnt <= 7'd0;
      end else if (pop) begin
        wcnt <= wcnt + 7'd1;
      end
      if (cmd_fire) begin
        wr_ptr  <= (ptr_adv == RING_END) ? RING_BASE : ptr_adv[28:0];
        blk_cnt <= blk_cnt + 16'd1;
        last    <= sel;
      end
    end
  end

  assign ch_rd                  = pop ? (4'b0001 << sel) : 4'b0000;
  assign p2.p2_wr_en            = pop;
  assign p2.p2_wr_data          = ch_dat[{sel, 5'b00000} +: 32];
  assign p2.p2_wr_mask          = 4'b0000;
  assign p2.p2_cmd_en           = cmd_fire;
  assign p2.p2_cmd_instr        = MCB_CMD_WR_AP;
  assign p2.p2_cmd_bl           = wcnt_m1[5:0];
  assign p2.p2_cmd_byte_addr    = {1'b0, wr_ptr};

  always_comb begin
    status = 32'd0;
    if (!wb_rst) begin
      status[STAT_STATE_LSB +: 3]   = state;
      status[STAT_RING_FULL]        = ring_full;
      status[STAT_LAST_LSB +: 2]    = last;
      status[STAT_BLKCNT_LSB +: 16] = blk_cnt;
    end
  end

endmodule

// File: tb/tb_gtp_wr_sched.sv
// Self-checking bench for gtp_wr_sched: channel FIFOs and ring pointer are modelled
// with queues and modular arithmetic; each scenario task checks its own results.
module tb_gtp_wr_sched;

  localparam int          BL    = 16;
  localparam logic [28:0] BASE  = 29'h100;
  localparam logic [28:0] BYTES = 29'h200;
  localparam int          BLK_B = 4 * BL;
  localparam int          FLUSH = 20;

  logic         wb_clk = 1'b0;
  logic         wb_rst;
  logic         enable;
  logic [127:0] ch_dat;
  logic [3:0]   ch_empty, ch_rdy, ch_rd;
  logic [28:0]  rd_ptr, wr_ptr;
  logic [31:0]  status;

  gtp_wr_sched_if p2_if ();

  gtp_wr_sched #(
    .BLOCK_LEN(BL), .RING_BASE(BASE), .RING_BYTES(BYTES)
`ifdef GTP_WR_FLUSH_EN
    , .FLUSH_CYCLES(FLUSH)
`endif
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .ch_dat(ch_dat),
    .ch_empty(ch_empty), .ch_rdy(ch_rdy), .ch_rd(ch_rd), .rd_ptr(rd_ptr),
    .wr_ptr(wr_ptr), .status(status), .p2(p2_if)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int proto_bad;
  bit track_rd;
  logic [28:0] model_ptr;

  logic [31:0] chq  [4][$];
  logic [31:0] sent [4][$];
  logic [31:0] wr_dat_q[$];
  int          wr_ch_q[$];
  int          wr_cyc_q[$];
  logic [5:0]  cmd_bl_q[$];
  logic [29:0] cmd_addr_q[$];
  int          cmd_cyc_q[$];

  function automatic logic [28:0] next_ptr(input logic [28:0] p);
    logic [31:0] off;
    off = (32'(p) - 32'(BASE) + 32'(BLK_B)) % 32'(BYTES);
    return BASE + off[28:0];
  endfunction

  task automatic push_words(input int ch, input int n, input bit rnd);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? $urandom : 32'(i);
      chq[ch].push_back(w);
      sent[ch].push_back(w);
    end
  endtask

  task automatic clear_logs();
    wr_dat_q.delete(); wr_ch_q.delete(); wr_cyc_q.delete();
    cmd_bl_q.delete(); cmd_addr_q.delete(); cmd_cyc_q.delete();
    proto_bad = 0;
  endtask

  // One clock: drive FIFO view, observe at negedge, commit pops and pointer at posedge.
  task automatic step();
    int nrd;
    int rch;
    bit adv;
    for (int k = 0; k < 4; k++) begin
      ch_empty[k] = (chq[k].size() == 0);
      ch_rdy[k]   = (chq[k].size() >= BL);
      ch_dat[32*k +: 32] = (chq[k].size() != 0) ? chq[k][0] : (32'hDEAD0000 | 32'(k));
    end
    if (track_rd) rd_ptr = model_ptr;
    @(negedge wb_clk);
    nrd = 0;
    rch = 0;
    adv = 1'b0;
    for (int k = 0; k < 4; k++) if (ch_rd[k] === 1'b1) begin nrd++; rch = k; end
    if (nrd > 1 || ((nrd == 1) != (p2_if.p2_wr_en === 1'b1))) proto_bad++;
    if (p2_if.p2_wr_en === 1'b1) begin
      if (p2_if.p2_wr_full) proto_bad++;
      wr_dat_q.push_back(p2_if.p2_wr_data);
      wr_ch_q.push_back(nrd == 1 ? rch : -1);
      wr_cyc_q.push_back(cyc);
    end
    if (nrd == 1) begin
      if (chq[rch].size() == 0) proto_bad++;
      else void'(chq[rch].pop_front());
    end
    if (p2_if.p2_cmd_en === 1'b1) begin
      if (p2_if.p2_cmd_full) proto_bad++;
      cmd_bl_q.push_back(p2_if.p2_cmd_bl);
      cmd_addr_q.push_back(p2_if.p2_cmd_byte_addr);
      cmd_cyc_q.push_back(cyc);
      adv = 1'b1;
    end
    @(posedge wb_clk);
    if (wb_rst) model_ptr = BASE;
    else if (adv) model_ptr = next_ptr(model_ptr);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    enable = 1'b1;
    p2_if.p2_wr_full  = 1'b0;
    p2_if.p2_cmd_full = 1'b0;
    track_rd = 1'b1;
    for (int k = 0; k < 4; k++) begin chq[k].delete(); sent[k].delete(); end
    step();
    step();
    wb_rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    enable = 1'b1;
    p2_if.p2_wr_full  = 1'b0;
    p2_if.p2_cmd_full = 1'b0;
    track_rd = 1'b1;
    model_ptr = BASE;
    push_words(0, BL, 1'b1);
    step();
    step();
    checks++;
    if (status !== 32'd0) begin errors++; $display("[TB] FAIL reset_status: got %0h expected 0", status); end
    checks++;
    if (ch_rd !== 4'd0 || p2_if.p2_wr_en !== 1'b0 || p2_if.p2_cmd_en !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got rd=%0h wr=%0b cmd=%0b expected 0", ch_rd, p2_if.p2_wr_en, p2_if.p2_cmd_en);
    end
    checks++;
    if (wr_ptr !== BASE) begin errors++; $display("[TB] FAIL reset_wr_ptr: got %0h expected %0h", wr_ptr, BASE); end
    for (int k = 0; k < 4; k++) begin chq[k].delete(); sent[k].delete(); end
    wb_rst = 1'b0;
    step();
    checks++;
    if (status[2:0] !== 3'd0 || status[5:4] !== 2'd3 || status[31:16] !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_release_status: got %0h expected state 0 last 3 count 0", status);
    end
    checks++;
    if (p2_if.p2_cmd_instr !== 3'b010 || p2_if.p2_wr_mask !== 4'd0) begin
      errors++; $display("[TB] FAIL const_outputs: got instr=%0b mask=%0h expected 010/0", p2_if.p2_cmd_instr, p2_if.p2_wr_mask);
    end
  endtask

  task automatic test_single_block();
    int start;
    int bad;
    do_reset();
    push_words(0, BL, 1'b0);
    start = cyc;
    for (int c = 0; c < 40 && cmd_cyc_q.size() == 0; c++) step();
    checks++;
    if (wr_dat_q.size() != BL) begin errors++; $display("[TB] FAIL single_count: got %0d expected %0d", wr_dat_q.size(), BL); end
    bad = 0;
    for (int i = 0; i < wr_dat_q.size(); i++)
      if (wr_dat_q[i] !== 32'(i) || wr_ch_q[i] != 0 || wr_cyc_q[i] != start + 1 + i) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL single_data: got %0d bad words expected 0", bad); end
    checks++;
    if (cmd_cyc_q.size() != 1) begin
      errors++; $display("[TB] FAIL single_cmd_count: got %0d expected 1", cmd_cyc_q.size());
    end else begin
      checks++;
      if (cmd_bl_q[0] !== 6'(BL - 1) || cmd_addr_q[0] !== {1'b0, BASE}) begin
        errors++; $display("[TB] FAIL single_cmd: got bl=%0d addr=%0h expected bl=%0d addr=%0h", cmd_bl_q[0], cmd_addr_q[0], BL - 1, BASE);
      end
      checks++;
      if (cmd_cyc_q[0] != start + BL + 1) begin
        errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", cmd_cyc_q[0] - start, BL + 1);
      end
    end
    checks++;
    if (wr_ptr !== BASE + 29'(BLK_B)) begin errors++; $display("[TB] FAIL single_wr_ptr: got %0h expected %0h", wr_ptr, BASE + 29'(BLK_B)); end
    checks++;
    if (proto_bad != 0) begin errors++; $display("[TB] FAIL single_protocol: got %0d violations expected 0", proto_bad); end
  endtask

  task automatic test_round_robin();
    int sz[4];
    int lst;
    int exp_ch[$];
    int bad;
    logic [31:0] w;
    do_reset();
    push_words(0, 2 * BL, 1'b1);
    for (int k = 1; k < 4; k++) push_words(k, BL, 1'b1);
    sz = '{2 * BL, BL, BL, BL};
    lst = 3;
    repeat (5) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (lst + k) % 4;
        if (sz[c] >= BL) begin exp_ch.push_back(c); sz[c] -= BL; lst = c; break; end
      end
    end
    for (int c = 0; c < 150 && cmd_cyc_q.size() < 5; c++) step();
    checks++;
    if (cmd_cyc_q.size() != 5 || wr_dat_q.size() != 5 * BL) begin
      errors++; $display("[TB] FAIL rr_counts: got %0d cmds %0d words expected 5 and %0d", cmd_cyc_q.size(), wr_dat_q.size(), 5 * BL);
    end else begin
      bad = 0;
      for (int b = 0; b < 5; b++) begin
        for (int i = 0; i < BL; i++) begin
          w = sent[exp_ch[b]].pop_front();
          if (wr_ch_q[b*BL + i] != exp_ch[b] || wr_dat_q[b*BL + i] !== w) bad++;
        end
      end
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL rr_order_data: got %0d bad words expected 0", bad); end
      bad = 0;
      for (int b = 1; b < 5; b++) if (cmd_cyc_q[b] - cmd_cyc_q[b-1] != BL + 2) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL rr_block_period: got %0d bad gaps expected 0", bad); end
      bad = 0;
      for (int b = 0; b < 5; b++) if (cmd_addr_q[b] !== {1'b0, BASE + 29'(b * BLK_B)}) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL rr_addresses: got %0d bad addresses expected 0", bad); end
    end
    checks++;
    if (status[31:16] !== 16'd5 || status[5:4] !== 2'(exp_ch[4])) begin
      errors++; $display("[TB] FAIL rr_status: got count=%0d last=%0d expected 5 and %0d", status[31:16], status[5:4], exp_ch[4]);
    end
  endtask

  task automatic test_backpressure();
    int start;
    int stalled;
    int bad;
    logic [31:0] w;
    do_reset();
    push_words(1, BL, 1'b1);
    start = cyc;
    stalled = 0;
    for (int c = 0; c < 60 && cmd_cyc_q.size() == 0; c++) begin
      if (wr_dat_q.size() == 5 && stalled < 3) begin p2_if.p2_wr_full = 1'b1; stalled++; end
      else p2_if.p2_wr_full = 1'b0;
      step();
    end
    p2_if.p2_wr_full = 1'b0;
    bad = 0;
    for (int i = 0; i < wr_dat_q.size(); i++) begin
      w = sent[1][i];
      if (wr_dat_q[i] !== w || wr_ch_q[i] != 1) bad++;
    end
    checks++;
    if (bad != 0 || wr_dat_q.size() != BL) begin
      errors++; $display("[TB] FAIL bp_data: got %0d words %0d bad expected %0d intact", wr_dat_q.size(), bad, BL);
    end
    checks++;
    if (proto_bad != 0) begin errors++; $display("[TB] FAIL bp_no_pop_when_full: got %0d violations expected 0", proto_bad); end
    checks++;
    if (cmd_cyc_q.size() != 1 || cmd_cyc_q[0] != start + BL + 4) begin
      errors++; $display("[TB] FAIL bp_block_cycles: got %0d cmds at +%0d expected 1 at +%0d",
                         cmd_cyc_q.size(), (cmd_cyc_q.size() != 0) ? cmd_cyc_q[0] - start : -1, BL + 4);
    end
  endtask

  task automatic test_wrap_ring_full();
    int bad;
    do_reset();
    push_words(2, 8 * BL, 1'b1);
    for (int c = 0; c < 170 && cmd_cyc_q.size() < 8; c++) step();
    checks++;
    if (cmd_cyc_q.size() != 8) begin
      errors++; $display("[TB] FAIL wrap_cmd_count: got %0d expected 8", cmd_cyc_q.size());
    end else begin
      bad = 0;
      for (int b = 0; b < 8; b++)
        if (cmd_addr_q[b] !== {1'b0, BASE + 29'((b * BLK_B) % int'(BYTES))}) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL wrap_addresses: got %0d bad expected 0", bad); end
      checks++;
      if (cmd_addr_q[7] !== {1'b0, BASE + BYTES - 29'(BLK_B)}) begin
        errors++; $display("[TB] FAIL wrap_last_addr: got %0h expected %0h", cmd_addr_q[7], BASE + BYTES - 29'(BLK_B));
      end
    end
    checks++;
    if (wr_ptr !== BASE) begin errors++; $display("[TB] FAIL wrap_wr_ptr: got %0h expected %0h", wr_ptr, BASE); end

    clear_logs();
    track_rd = 1'b0;
    rd_ptr = next_ptr(model_ptr);
    push_words(3, BL, 1'b1);
    repeat (25) step();
    checks++;
    if (wr_dat_q.size() != 0 || cmd_cyc_q.size() != 0) begin
      errors++; $display("[TB] FAIL ring_full_blocks: got %0d writes expected 0", wr_dat_q.size());
    end
    checks++;
    if (status[3] !== 1'b1) begin errors++; $display("[TB] FAIL ring_full_flag: got %0b expected 1", status[3]); end
    rd_ptr = next_ptr(next_ptr(model_ptr));
    for (int c = 0; c < 40 && cmd_cyc_q.size() == 0; c++) step();
    checks++;
    if (cmd_cyc_q.size() != 1 || wr_dat_q.size() != BL || cmd_addr_q[0] !== {1'b0, BASE}) begin
      errors++; $display("[TB] FAIL ring_release: got %0d cmds %0d words expected 1 block at %0h", cmd_cyc_q.size(), wr_dat_q.size(), BASE);
    end
    track_rd = 1'b1;
  endtask

  task automatic test_cmd_full();
    int start;
    int held;
    do_reset();
    push_words(3, BL, 1'b1);
    start = cyc;
    held = 0;
    for (int c = 0; c < 60 && cmd_cyc_q.size() == 0; c++) begin
      if (wr_dat_q.size() == BL && held < 10) begin p2_if.p2_cmd_full = 1'b1; held++; end
      else p2_if.p2_cmd_full = 1'b0;
      step();
    end
    p2_if.p2_cmd_full = 1'b0;
    repeat (3) step();
    checks++;
    if (cmd_cyc_q.size() != 1) begin errors++; $display("[TB] FAIL cmdfull_pulses: got %0d expected 1", cmd_cyc_q.size()); end
    else begin
      checks++;
      if (cmd_cyc_q[0] != start + BL + 11) begin
        errors++; $display("[TB] FAIL cmdfull_timing: got +%0d expected +%0d", cmd_cyc_q[0] - start, BL + 11);
      end
    end
    checks++;
    if (proto_bad != 0) begin errors++; $display("[TB] FAIL cmdfull_protocol: got %0d violations expected 0", proto_bad); end
  endtask

  task automatic test_reset_mid_xfer();
    do_reset();
    push_words(1, 2 * BL, 1'b1);
    for (int c = 0; c < 60 && wr_dat_q.size() < BL + 6; c++) step();
    checks++;
    if (wr_ptr !== BASE + 29'(BLK_B)) begin errors++; $display("[TB] FAIL midrst_pre_ptr: got %0h expected %0h", wr_ptr, BASE + 29'(BLK_B)); end
    wb_rst = 1'b1;
    step();
    checks++;
    if (ch_rd !== 4'd0 || p2_if.p2_wr_en !== 1'b0 || p2_if.p2_cmd_en !== 1'b0 || status !== 32'd0) begin
      errors++; $display("[TB] FAIL midrst_strobes: got rd=%0h wr=%0b cmd=%0b status=%0h expected all 0",
                         ch_rd, p2_if.p2_wr_en, p2_if.p2_cmd_en, status);
    end
    checks++;
    if (wr_ptr !== BASE) begin errors++; $display("[TB] FAIL midrst_wr_ptr: got %0h expected %0h", wr_ptr, BASE); end
    for (int k = 0; k < 4; k++) begin chq[k].delete(); sent[k].delete(); end
    wb_rst = 1'b0;
    clear_logs();
    repeat (5) step();
    checks++;
    if (status[2:0] !== 3'd0 || wr_dat_q.size() != 0) begin
      errors++; $display("[TB] FAIL midrst_idle: got state=%0d writes=%0d expected 0/0", status[2:0], wr_dat_q.size());
    end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    push_words(0, BL, 1'b1);
    repeat (20) step();
    checks++;
    if (wr_dat_q.size() != 0) begin errors++; $display("[TB] FAIL enable_low_grant: got %0d writes expected 0", wr_dat_q.size()); end
    enable = 1'b1;
    for (int c = 0; c < 20 && wr_dat_q.size() < 3; c++) step();
    enable = 1'b0;
    for (int c = 0; c < 40 && cmd_cyc_q.size() == 0; c++) step();
    checks++;
    if (wr_dat_q.size() != BL || cmd_cyc_q.size() != 1) begin
      errors++; $display("[TB] FAIL enable_drop_completes: got %0d words %0d cmds expected %0d/1", wr_dat_q.size(), cmd_cyc_q.size(), BL);
    end
    enable = 1'b1;
  endtask

  task automatic test_partial();
    int bad;
    do_reset();
    push_words(2, 5, 1'b1);
`ifdef GTP_WR_FLUSH_EN
    for (int c = 0; c < FLUSH + 40 && cmd_cyc_q.size() == 0; c++) step();
    bad = 0;
    for (int i = 0; i < wr_dat_q.size(); i++) if (wr_dat_q[i] !== sent[2][i] || wr_ch_q[i] != 2) bad++;
    checks++;
    if (wr_dat_q.size() != 5 || bad != 0) begin
      errors++; $display("[TB] FAIL flush_data: got %0d words %0d bad expected 5 intact", wr_dat_q.size(), bad);
    end
    checks++;
    if (cmd_cyc_q.size() != 1 || cmd_bl_q[0] !== 6'd4) begin
      errors++; $display("[TB] FAIL flush_cmd: got %0d cmds bl=%0d expected 1 with bl=4", cmd_cyc_q.size(), (cmd_bl_q.size() != 0) ? cmd_bl_q[0] : 6'd0);
    end
    checks++;
    if (wr_ptr !== BASE + 29'(BLK_B)) begin errors++; $display("[TB] FAIL flush_wr_ptr: got %0h expected %0h", wr_ptr, BASE + 29'(BLK_B)); end
`else
    repeat (60) step();
    bad = wr_dat_q.size() + cmd_cyc_q.size();
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL partial_waits: got %0d writes/cmds expected 0", bad); end
    checks++;
    if (wr_ptr !== BASE) begin errors++; $display("[TB] FAIL partial_wr_ptr: got %0h expected %0h", wr_ptr, BASE); end
`endif
  endtask

  initial begin
    ch_dat   = '0;
    ch_empty = 4'hF;
    ch_rdy   = 4'h0;
    rd_ptr   = BASE;
    test_reset();
    test_single_block();
    test_round_robin();
    test_backpressure();
    test_wrap_ring_full();
    test_cmd_full();
    test_reset_mid_xfer();
    test_enable();
    test_partial();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gtp_wr_sched.md
# gtp_wr_sched

Scheduler for MCB port 2, the GTP data write path into DDR3 SDRAM. Drains four per-receiver channel FIFOs (already in the `wb_clk` domain, first-word-fall-through) into the port 2 write FIFO in fixed-size blocks. Selects channels with round-robin arbitration and issues one write-with-autoprecharge command per block. Addresses are drawn from a circular region of SDRAM, with ring-full protection against the consumer read pointer.

## Interface
- `BLOCK_LEN`, 16: words (32-bit) per block, 2..64; command `bl` = `BLOCK_LEN-1`.
- `RING_BASE`, 29'h0000000: byte address of ring start; aligned to `4*BLOCK_LEN`.
- `RING_BYTES`, 29'h1000000: ring size in bytes; a multiple of `4*BLOCK_LEN`.
- `FLUSH_CYCLES`, 1024: idle timeout for partial-block flush (used only with the macro).

Ports:
- `wb_clk`  in  1: sole clock.
- `wb_rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: when low, no new grant is issued; a block in progress completes.
- `ch_dat`  in  128: channel words; ch*i* = bits [32i+31:32i].
- `ch_empty`  in  4: channel FIFO empty.
- `ch_rdy`  in  4: channel holds ≥ `BLOCK_LEN` words.
- `ch_rd`  out  4: pop strobe, at most one bit set.
- `rd_ptr`  in  29: consumer byte pointer into the ring.
- `wr_ptr`  out  29: byte address of the next block.
- `p2_wr_en`  out  1; `p2_wr_data`  out  32; `p2_wr_mask`  out  4 (always 0); `p2_wr_full`  in  1.
- `p2_cmd_en`  out  1; `p2_cmd_instr`  out  3 (always 3'b010); `p2_cmd_bl`  out  6; `p2_cmd_byte_addr`  out  30 (`{1'b0, wr_ptr}`); `p2_cmd_full`  in  1.
- `status`  out  32:
  - [2:0] state.
  - [3] ring_full.
  - [5:4] last grant.
  - [15:6] zero.
  - [31:16] blocks-written counter, wraps.

## Operation
- States: `ST_IDLE`, `ST_XFER`, `ST_CMD`.
- **`ST_IDLE`**
  - Condition to grant: `enable`, not ring_full, and some `ch_rdy` bit set.
  - Grant goes to the first ready channel searched from `last+1` mod 4.
  - On grant: register `sel`, clear word counter `wcnt`, move to `ST_XFER`.
- **`ST_XFER`**
  - Pop/write condition, evaluated combinationally: `wcnt < BLOCK_LEN & ~ch_empty[sel] & ~p2_wr_full`.
  - When true, `ch_rd[sel] = p2_wr_en = 1`, `p2_wr_data = ch_dat[sel]`, and `wcnt` increments.
  - When `wcnt` reaches `BLOCK_LEN`, move to `ST_CMD`.
  - Backpressure (`p2_wr_full`) or a transiently empty channel stalls without losing words.
- **`ST_CMD`**
  - When `~p2_cmd_full`: pulse `p2_cmd_en` for one cycle with `bl = wcnt-1` and address `wr_ptr`.
  - On the same pulse: advance `wr_ptr` by `4*BLOCK_LEN`, increment the block counter, set `last = sel`, return to `ST_IDLE`.
  - While `p2_cmd_full` is high, hold in `ST_CMD`.
- **Wrap-around:** if `wr_ptr + 4*BLOCK_LEN == RING_BASE + RING_BYTES`, the next `wr_ptr` is `RING_BASE`.
- **ring_full** = ((`rd_ptr - wr_ptr`) mod `RING_BYTES`) ∈ [1, `4*BLOCK_LEN`].
  - `rd_ptr == wr_ptr` means the ring is empty.
  - ring_full is evaluated only in `ST_IDLE`.
- **Simultaneous requests:** resolved purely by round-robin order. No channel waits more than 3 blocks once ready.
- **Reset, including mid-block:**
  - `state = ST_IDLE`, `wr_ptr = RING_BASE`, `last = 3` (so ch0 has first priority), counters = 0.
  - All strobes (`ch_rd`, `p2_wr_en`, `p2_cmd_en`) = 0 and `status = 0`.
  - Words already written to the port 2 FIFO are discarded by the MCB reset on the same `wb_rst`.

## Timing
- Grant is registered: `ch_rdy` sampled in cycle N → first pop in N+1.
- Data path is combinational: the pop cycle equals the `p2_wr_en` cycle, with zero latency.
- Block without backpressure takes `BLOCK_LEN+2` cycles (1 idle + `BLOCK_LEN` xfer + 1 cmd).
- The command is issued strictly after the last data word.
- `wr_ptr` updates on the cycle after `p2_cmd_en`.

## Configuration
- `GTP_WR_FLUSH_EN`
  - **Defined:**
    - A per-channel idle counter increments while the channel is non-empty but not `ch_rdy`.
    - At `FLUSH_CYCLES` the channel becomes eligible for grant.
    - `ST_XFER` ends when `ch_empty[sel]` or `wcnt == BLOCK_LEN`; the command uses `bl = wcnt-1`.
    - `wr_ptr` still advances by a full block, keeping alignment.
    - The counter clears on grant or when the channel goes empty.
  - **Undefined:** only full blocks are written; partial data waits indefinitely.

## Structure
- Package `gtp_wr_pkg`: state encoding, `MCB_CMD_WR_AP = 3'b010`, status field bit positions.
- Sub-module `rr_arb4`: inputs `req[3:0]` and `last[1:0]`; outputs `gnt_vld` and `gnt[1:0]`; purely combinational.

## Test plan
- Reset, then ch0 `ch_rdy` with 16 words 0..15 → 16 consecutive `p2_wr_en` with data 0..15, then `p2_cmd_en` with bl=15, addr=`RING_BASE`; `wr_ptr` = `RING_BASE`+64.
- All four `ch_rdy` held high → grants in order 0,1,2,3,0; each block 18 cycles; `status[31:16]` = 5.
- `p2_wr_full` asserted for 3 cycles at word 5 → no pop during the stall; 16 words delivered intact; block takes 21 cycles.
- `wr_ptr` = `RING_BASE+RING_BYTES-64` → block at that address, then `wr_ptr` wraps to `RING_BASE`. With `rd_ptr` = `wr_ptr`+64, ring_full=1 and no grant even with `ch_rdy`.
- `p2_cmd_full` high for 10 cycles in `ST_CMD` → `p2_cmd_en` held off, then a single pulse. `wb_rst` mid-`ST_XFER` → next cycle all strobes 0, `state` `ST_IDLE`, `wr_ptr` = `RING_BASE`.
- (`GTP_WR_FLUSH_EN`) ch2 holds 5 words, idle for `FLUSH_CYCLES` → 5 writes, then command with bl=4; `wr_ptr` advances 64.
